// File: rtl/compressor_input_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : compressor_input_arbiter
// Purpose  : Frame-locked round-robin arbiter that merges NUM_CH beat streams
//            into a single compressor input stream.
// Revision : 1.0
// ----------------------------------------------------------------------------
module compressor_input_arbiter #(
  parameter int DATA_WIDTH = 256,
  parameter int NUM_CH     = 4,
  parameter int CH_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wrt_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_CH-1:0]            s_tvalid,
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic [NUM_CH-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [CH_WIDTH-1:0]          grant_id,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         frame_cnt
);

  localparam logic [0:0] c_idle = 1'b0;
  localparam logic [0:0] c_busy = 1'b1;

  logic [0:0]            r_state;
  logic [CH_WIDTH-1:0]   r_grant;
  logic [CH_WIDTH-1:0]   r_rr_ptr;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;

  logic                  w_active;
  logic                  w_any_valid;
  logic [CH_WIDTH-1:0]   w_pick;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [NUM_CH-1:0]     w_ready;
  logic                  w_xfer;

  function automatic logic [CH_WIDTH-1:0] f_ch_add(input logic [CH_WIDTH-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    return CH_WIDTH'(sum % 32'(NUM_CH));
  endfunction

  // Outputs are forced quiet while reset is held, even if a frame was in flight.
  assign w_active = (r_state == c_busy) && !reset;

  // Walk offsets from high to low so the nearest channel above rr_ptr wins.
  always_comb begin
    w_any_valid = 1'b0;
    w_pick      = r_rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (s_tvalid[f_ch_add(r_rr_ptr, k)]) begin
        w_any_valid = 1'b1;
        w_pick      = f_ch_add(r_rr_ptr, k);
      end
    end
  end

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_ready     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_active && (r_grant == CH_WIDTH'(i))) begin
        w_sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_valid = s_tvalid[i];
        w_sel_last  = s_tlast[i];
        w_ready[i]  = m_tready & wrt_en;
      end
    end
  end

  assign w_xfer    = w_active & wrt_en & w_sel_valid & m_tready;

  assign m_data    = w_sel_data;
  assign m_tlast   = w_sel_last;
  assign m_tvalid  = w_sel_valid & wrt_en;
  assign s_tready  = w_ready;
  assign busy      = w_active;
  assign grant_id  = r_grant;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_idle;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_frame_cnt <= '0;
    end else if (wrt_en) begin
      if (r_state == c_idle) begin
        if (w_any_valid) begin
          r_grant <= w_pick;
          r_state <= c_busy;
        end
      end else if (w_xfer && w_sel_last) begin
        r_state     <= c_idle;
        r_rr_ptr    <= f_ch_add(r_grant, 1);
        r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compressor_input_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_compressor_input_arbiter
// Purpose  : Scenario and randomized bench for compressor_input_arbiter.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_compressor_input_arbiter;

  localparam int DW = 256;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int KW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset    = 1'b1;
  logic          wrt_en   = 1'b1;
  logic          m_tready = 1'b0;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]  s_tvalid = '0;
  logic [N-1:0]  s_tlast  = '0;

  logic [N-1:0]  s_tready, s_tready_w;
  logic [DW-1:0] m_data, m_data_w;
  logic          m_tvalid, m_tvalid_w, m_tlast, m_tlast_w, busy, busy_w;
  logic [CW-1:0] grant_id, grant_id_w;
  logic [KW-1:0] frame_cnt;
  logic [2:0]    frame_cnt_w;

  compressor_input_arbiter #(.DATA_WIDTH(DW), .NUM_CH(N), .CH_WIDTH(CW), .CNT_WIDTH(KW)) u_dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en), .s_data(s_data), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .m_data(m_data), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready), .grant_id(grant_id), .busy(busy),
    .frame_cnt(frame_cnt));

  // Narrow counter copy so counter wrap-around is reachable in a short run.
  compressor_input_arbiter #(.DATA_WIDTH(DW), .NUM_CH(N), .CH_WIDTH(CW), .CNT_WIDTH(3)) u_dut_w (
    .clk(clk), .reset(reset), .wrt_en(wrt_en), .s_data(s_data), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready_w), .m_data(m_data_w), .m_tvalid(m_tvalid_w),
    .m_tlast(m_tlast_w), .m_tready(m_tready), .grant_id(grant_id_w), .busy(busy_w),
    .frame_cnt(frame_cnt_w));

  int checks   = 0;
  int failures = 0;

  // Reference model: owner channel (-1 = none), round-robin pointer, frame count.
  int          mo_owner = -1;
  int          mo_grant = 0;
  int          mo_rr    = 0;
  int unsigned mo_cnt   = 0;

  logic          exp_busy, exp_tvalid, exp_tlast, exp_xfer;
  logic [N-1:0]  exp_ready;
  logic [DW-1:0] exp_data;

  // Traffic sources
  bit [N-1:0] src_on = '0;
  int src_len[N];
  int src_idx[N];
  int src_left[N];
  int src_fno[N];
  int src_maxlen = 0;
  int gap_pct    = 0;
  int rdy_mode   = 0;
  int cyc        = 0;

  function automatic logic [DW-1:0] beat(input int ch, input int fno, input int idx);
    logic [DW-1:0] b;
    for (int w = 0; w < DW / 32; w++) b[w*32 +: 32] = $urandom;
    b[31:0] = {8'(ch), 8'(fno), 16'(idx)};
    return b;
  endfunction

  task automatic start_src(input int ch, input int len, input int frames);
    src_on[ch]   = 1'b1;
    src_len[ch]  = len;
    src_left[ch] = frames;
    src_idx[ch]  = 0;
  endtask

  task automatic calc_exp();
    exp_busy   = 1'b0;
    exp_tvalid = 1'b0;
    exp_tlast  = 1'b0;
    exp_ready  = '0;
    exp_data   = '0;
    if (!reset && mo_owner >= 0) begin
      exp_busy            = 1'b1;
      exp_tvalid          = s_tvalid[mo_owner] & wrt_en;
      exp_tlast           = s_tlast[mo_owner];
      exp_data            = s_data[mo_owner*DW +: DW];
      exp_ready[mo_owner] = m_tready & wrt_en;
    end
    exp_xfer = exp_tvalid & m_tready;
  endtask

  task automatic drive();
    @(negedge clk);
    for (int c = 0; c < N; c++) begin
      s_tvalid[c] = src_on[c] && (int'($urandom_range(99)) >= gap_pct);
      s_tlast[c]  = (src_idx[c] == src_len[c] - 1);
      s_data[c*DW +: DW] = beat(c, src_fno[c], src_idx[c]);
    end
    case (rdy_mode)
      1:       m_tready = 1'($urandom_range(1));
      2:       m_tready = (cyc % 2 == 0);
      default: m_tready = 1'b1;
    endcase
    cyc++;
    #1;
    calc_exp();
  endtask

  task automatic advance();
    bit found;
    @(posedge clk);
    if (reset) begin
      mo_owner = -1; mo_grant = 0; mo_rr = 0; mo_cnt = 0;
      for (int c = 0; c < N; c++) src_idx[c] = 0;
    end else if (wrt_en) begin
      if (mo_owner < 0) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && s_tvalid[(mo_rr + k) % N]) begin
            found = 1; mo_owner = (mo_rr + k) % N; mo_grant = mo_owner;
          end
        end
      end else if (exp_xfer) begin
        if (s_tlast[mo_owner]) begin
          src_idx[mo_owner] = 0;
          src_fno[mo_owner]++;
          src_left[mo_owner]--;
          if (src_left[mo_owner] <= 0) src_on[mo_owner] = 1'b0;
          if (src_maxlen > 0) src_len[mo_owner] = $urandom_range(src_maxlen, 1);
          mo_rr    = (mo_owner + 1) % N;
          mo_cnt   = (mo_cnt + 1) % 65536;
          mo_owner = -1;
        end else begin
          src_idx[mo_owner]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    src_on = '0;
    reset  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wrt_en = (k == 0);
      drive();
      checks++;
      if ({busy, m_tvalid, m_tlast, s_tready} !== 7'd0 || m_data !== '0) begin
        failures++;
        $display("FAIL reset_outputs busy=%0b tvalid=%0b tlast=%0b tready=%b want all 0", busy, m_tvalid, m_tlast, s_tready);
      end
      advance();
    end
    reset  = 1'b0;
    wrt_en = 1'b1;
    drive();
    checks++;
    if ({busy, m_tvalid, s_tready, grant_id} !== 8'd0 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_after busy=%0b tvalid=%0b tready=%b grant=%0d cnt=%0d want 0", busy, m_tvalid, s_tready, grant_id, frame_cnt);
    end
    advance();
  endtask

  task automatic test_single_frame();
    int  nx = 0;
    logic [5:0] mask = '0;
    start_src(2, 3, 1);
    for (int k = 0; k < 6; k++) begin
      drive();
      checks++;
      if ({busy, m_tvalid, m_tlast, s_tready} !== {exp_busy, exp_tvalid, exp_tlast, exp_ready}) begin
        failures++;
        $display("FAIL single_ctrl cyc=%0d got=%b want=%b", k, {busy, m_tvalid, m_tlast, s_tready}, {exp_busy, exp_tvalid, exp_tlast, exp_ready});
      end
      if (m_tvalid && m_tready) begin
        nx++;
        mask[k] = 1'b1;
        checks++;
        if (grant_id !== 2'd2 || m_tlast !== (nx == 3)) begin
          failures++;
          $display("FAIL single_beat n=%0d grant=%0d tlast=%0b want grant=2 tlast=%0b", nx, grant_id, m_tlast, nx == 3);
        end
      end
      advance();
    end
    checks++;
    if (mask !== 6'b001110 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_summary xfer_cycles=%b cnt=%0d want 001110 cnt=1", mask, frame_cnt);
    end
    // rr_ptr should now be 3, so ch3 beats ch0
    start_src(0, 1, 1);
    start_src(3, 1, 1);
    drive();
    advance();
    drive();
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL single_rrptr busy=%0b grant=%0d want busy=1 grant=3", busy, grant_id);
    end
    advance();
    for (int k = 0; k < 4; k++) begin drive(); advance(); end
  endtask

  task automatic test_round_robin();
    int nx = 0;
    do_reset();
    for (int c = 0; c < N; c++) start_src(c, 1, 100);
    for (int k = 0; k < 16; k++) begin
      drive();
      if (m_tvalid && m_tready) begin
        checks++;
        if (grant_id !== CW'(nx % N) || m_tlast !== 1'b1) begin
          failures++;
          $display("FAIL rr_grant n=%0d grant=%0d tlast=%0b want grant=%0d tlast=1", nx, grant_id, m_tlast, nx % N);
        end
        nx++;
      end
      advance();
    end
    src_on = '0;
    drive();
    checks++;
    if (nx !== 8 || frame_cnt !== 16'd8 || frame_cnt_w !== 3'd0) begin
      failures++;
      $display("FAIL rr_rate frames=%0d cnt=%0d cnt3=%0d want 8 8 0", nx, frame_cnt, frame_cnt_w);
    end
    advance();
  endtask

  task automatic test_hold_grant();
    int first_g1 = -1;
    do_reset();
    start_src(0, 4, 1);
    drive();
    advance();
    start_src(1, 2, 1);
    for (int k = 0; k < 10; k++) begin
      drive();
      checks++;
      if ({busy, s_tready} !== {exp_busy, exp_ready} || (exp_busy && grant_id !== CW'(mo_grant))) begin
        failures++;
        $display("FAIL hold_ctrl cyc=%0d busy=%0b tready=%b grant=%0d want %0b %b %0d", k, busy, s_tready, grant_id, exp_busy, exp_ready, mo_grant);
      end
      if (first_g1 < 0 && busy === 1'b1 && grant_id === 2'd1) first_g1 = k;
      advance();
    end
    checks++;
    if (first_g1 !== 5) begin
      failures++;
      $display("FAIL hold_ch1_grant_cycle got=%0d want=5", first_g1);
    end
  endtask

  task automatic test_backpressure();
    int nx = 0;
    do_reset();
    cyc      = 0;
    rdy_mode = 2;
    start_src(3, 4, 1);
    for (int k = 0; k < 12; k++) begin
      drive();
      checks++;
      if ({m_tvalid, s_tready} !== {exp_tvalid, exp_ready} || m_data !== exp_data) begin
        failures++;
        $display("FAIL bp_ctrl cyc=%0d tvalid=%0b tready=%b want %0b %b", k, m_tvalid, s_tready, exp_tvalid, exp_ready);
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (m_data[15:0] !== 16'(nx) || m_data[31:24] !== 8'd3) begin
          failures++;
          $display("FAIL bp_order got=%h want ch=3 idx=%0d", m_data[31:0], nx);
        end
        nx++;
      end
      advance();
    end
    rdy_mode = 0;
    checks++;
    if (nx !== 4 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL bp_count xfers=%0d cnt=%0d want 4 1", nx, frame_cnt);
    end
  endtask

  task automatic test_wrt_en_freeze();
    int nx = 0;
    start_src(1, 6, 1);
    for (int k = 0; k < 3; k++) begin drive(); advance(); end
    wrt_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive();
      checks++;
      if ({busy, m_tvalid, s_tready, grant_id} !== {1'b1, 1'b0, 4'd0, 2'd1} || frame_cnt !== 16'd1) begin
        failures++;
        $display("FAIL freeze cyc=%0d busy=%0b tvalid=%0b tready=%b grant=%0d cnt=%0d want 1 0 0000 1 1", k, busy, m_tvalid, s_tready, grant_id, frame_cnt);
      end
      advance();
    end
    wrt_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive();
      if (m_tvalid && m_tready) begin
        checks++;
        if (m_data[15:0] !== 16'(nx + 2) || k !== nx) begin
          failures++;
          $display("FAIL freeze_resume cyc=%0d idx=%0d want idx=%0d at cyc=%0d", k, m_data[15:0], nx + 2, nx);
        end
        nx++;
      end
      advance();
    end
    checks++;
    if (nx !== 4 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL freeze_total xfers=%0d cnt=%0d want 4 2", nx, frame_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    int nx = 0;
    start_src(2, 5, 1);
    for (int k = 0; k < 3; k++) begin
      drive();
      checks++;
      if (m_tlast !== 1'b0) begin
        failures++;
        $display("FAIL midrst_pre_tlast cyc=%0d got=%0b want=0", k, m_tlast);
      end
      advance();
    end
    reset = 1'b1;
    drive();
    checks++;
    if ({busy, m_tvalid, m_tlast} !== 3'd0) begin
      failures++;
      $display("FAIL midrst_during busy=%0b tvalid=%0b tlast=%0b want 0", busy, m_tvalid, m_tlast);
    end
    advance();
    reset = 1'b0;
    drive();
    checks++;
    if (busy !== 1'b0 || grant_id !== 2'd0 || frame_cnt !== 16'd0 || m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after busy=%0b grant=%0d cnt=%0d tlast=%0b want 0 0 0 0", busy, grant_id, frame_cnt, m_tlast);
    end
    advance();
    for (int k = 0; k < 8; k++) begin
      drive();
      if (m_tvalid && m_tready) begin
        checks++;
        if (m_data[15:0] !== 16'(nx)) begin
          failures++;
          $display("FAIL midrst_restart idx=%0d want=%0d", m_data[15:0], nx);
        end
        nx++;
      end
      advance();
    end
    checks++;
    if (nx !== 5 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL midrst_total xfers=%0d cnt=%0d want 5 1", nx, frame_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    src_maxlen = 6;
    gap_pct    = 20;
    rdy_mode   = 1;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!src_on[c] && $urandom_range(7) == 0)
          start_src(c, int'($urandom_range(6, 1)), int'($urandom_range(3, 1)));
      end
      wrt_en = ($urandom_range(9) != 0);
      reset  = ($urandom_range(99) == 0);
      drive();
      checks++;
      if ({busy, m_tvalid, m_tlast, s_tready, grant_id} !== {exp_busy, exp_tvalid, exp_tlast, exp_ready, CW'(mo_grant)}
          || m_data !== exp_data || frame_cnt !== KW'(mo_cnt)) begin
        failures++;
        $display("FAIL rand_main cyc=%0d got=%b cnt=%0d want=%b cnt=%0d", k, {busy, m_tvalid, m_tlast, s_tready, grant_id}, frame_cnt,
                 {exp_busy, exp_tvalid, exp_tlast, exp_ready, CW'(mo_grant)}, mo_cnt);
      end
      checks++;
      if ({busy_w, m_tvalid_w, m_tlast_w, s_tready_w, grant_id_w} !== {exp_busy, exp_tvalid, exp_tlast, exp_ready, CW'(mo_grant)}
          || m_data_w !== exp_data || frame_cnt_w !== 3'(mo_cnt % 8)) begin
        failures++;
        $display("FAIL rand_narrow cyc=%0d cnt3=%0d want=%0d busy=%0b want=%0b", k, frame_cnt_w, mo_cnt % 8, busy_w, exp_busy);
      end
      advance();
    end
    reset  = 1'b0;
    wrt_en = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      src_len[c] = 1; src_idx[c] = 0; src_left[c] = 0; src_fno[c] = 0;
    end
    test_reset();
    test_single_frame();
    test_round_robin();
    test_hold_grant();
    test_backpressure();
    test_wrt_en_freeze();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compressor_input_arbiter.md
COMPRESSOR_INPUT_ARBITER -- requirements
Module: compressor_input_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 256, beat width; equals compressor input width (8 x 32).
REQ-002 Parameter NUM_CH, 4, number of requesting input streams.
REQ-003 Parameter CH_WIDTH, 2, channel index width; SHALL satisfy 2^CH_WIDTH >= NUM_CH.
REQ-004 Parameter CNT_WIDTH, 16, completed-frame counter width.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wrt_en  in  1  global enable; low freezes all state and blocks all transfers.
REQ-008 s_data  in  NUM_CH*DATA_WIDTH  channel i beat at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 s_tvalid  in  NUM_CH  per-channel beat valid.
REQ-010 s_tlast  in  NUM_CH  per-channel last beat of frame.
REQ-011 s_tready  out  NUM_CH  per-channel beat accept.
REQ-012 m_data  out  DATA_WIDTH  beat to the compressor.
REQ-013 m_tvalid  out  1  beat valid to the compressor.
REQ-014 m_tlast  out  1  frame end to the compressor.
REQ-015 m_tready  in  1  compressor accept (its not-full indication).
REQ-016 grant_id  out  CH_WIDTH  channel currently owning the compressor.
REQ-017 busy  out  1  high while a frame is locked to grant_id.
REQ-018 frame_cnt  out  CNT_WIDTH  total frames forwarded since reset.

Function
REQ-019 FSM SHALL have two states: IDLE (no owner) and BUSY (frame locked to grant_id).
REQ-020 Transfer on channel g SHALL occur in a cycle where state=BUSY, grant_id=g, wrt_en=1, s_tvalid[g]=1 and m_tready=1.
REQ-021 IDLE, wrt_en=1, any s_tvalid high: SHALL pick the first channel with s_tvalid high searching upward from rr_ptr modulo NUM_CH, load grant_id, enter BUSY next cycle.
REQ-022 Arbitration SHALL cost exactly one cycle; no beat transfers in IDLE (s_tready all 0, m_tvalid=0).
REQ-023 IDLE with no s_tvalid high: SHALL remain IDLE, grant_id and rr_ptr unchanged.
REQ-024 BUSY: m_data, m_tlast SHALL be combinational copies of channel grant_id; m_tvalid = s_tvalid[grant_id] & wrt_en.
REQ-025 BUSY: s_tready[grant_id] = m_tready & wrt_en; all other s_tready bits SHALL be 0.
REQ-026 Grant SHALL hold for the whole frame; other channels' s_tvalid/s_tlast SHALL be ignored until release.
REQ-027 Transfer with s_tlast[grant_id]=1: SHALL return to IDLE next cycle, set rr_ptr = (grant_id+1) mod NUM_CH, increment frame_cnt by 1.
REQ-028 frame_cnt SHALL wrap from 2^CNT_WIDTH-1 to 0.
REQ-029 Single-beat frame (tlast on first beat): SHALL occupy one BUSY cycle, then IDLE.
REQ-030 BUSY with s_tvalid[grant_id]=0 or m_tready=0: SHALL hold BUSY and grant, no transfer, no timeout.
REQ-031 wrt_en=0: FSM, grant_id, rr_ptr, frame_cnt SHALL hold; m_tvalid=0 and s_tready=0.
REQ-032 busy SHALL equal (state==BUSY).
REQ-033 Outside BUSY: m_data=0, m_tlast=0.

Reset
REQ-034 reset=1 SHALL force state=IDLE, grant_id=0, rr_ptr=0, frame_cnt=0 on the next edge, overriding wrt_en.
REQ-035 While reset=1 and the cycle after: busy=0, m_tvalid=0, m_tlast=0, m_data=0, s_tready=0.
REQ-036 Reset mid-frame SHALL abandon the frame without emitting m_tlast; the source restarts the frame.

Verification
REQ-037 Ch2 only, 3-beat frame, m_tready=1: one IDLE cycle, then grant_id=2, 3 consecutive transfers, m_tlast on beat 3, frame_cnt=1, rr_ptr=3.
REQ-038 All 4 channels send continuous 1-beat frames: grants 0,1,2,3,0... at one frame per 2 cycles; frame_cnt=8 after 16 cycles.
REQ-039 Ch0 mid-frame, ch1 raises s_tvalid: s_tready[1]=0 until ch0 tlast accepted; ch1 granted after one IDLE cycle.
REQ-040 m_tready toggles 1,0,1,0 during a 4-beat frame: exactly 4 transfers, no dropped or duplicated beats, m_data matches source order.
REQ-041 wrt_en=0 for 5 cycles mid-frame: no transfers, grant_id and frame_cnt hold; resumes on the next beat.
REQ-042 reset pulsed after beat 2 of a 5-beat frame: busy=0, frame_cnt=0, grant_id=0 next cycle; no m_tlast emitted.
